// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM state encoding and the word/byte geometry.
package imem_loader_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_HDR_LO,
      ST_HDR_HI,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERR
   } state_e;

   // States from which a new load session may be started.
   function automatic logic is_restartable(input state_e s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// word_full_o pulses combinationally on the handshake that completes a word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              accept_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_full_o
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);

   logic [LANE_W-1:0] lane_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lane_q <= '0;
      end else if (clear_i) begin
         lane_q <= '0;
      end else if (accept_i) begin
         lane_q <= lane_q + LANE_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         logic [BYTE_W-1:0] lane_byte_q;

         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               lane_byte_q <= '0;
            end else if (clear_i) begin
               lane_byte_q <= '0;
            end else if (accept_i && (lane_q == LANE_W'(gi))) begin
               lane_byte_q <= byte_i;
            end
         end

         assign word_o[gi*BYTE_W +: BYTE_W] = lane_byte_q;
      end
   endgenerate

   assign word_full_o = accept_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads the CPU instruction memory from a host byte stream: zero-fill,
// 16-bit little-endian word-count header, then little-endian data words.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int WORD_COUNT = 256,
   parameter int ADDR_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_req_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              cpu_start_o
);

   // One extra bit so that an index equal to WORD_COUNT is representable.
   localparam int IDX_W = ADDR_W + 1;

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   count_q;
   logic               ready_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic               start_q;

   logic               accept;
   logic               load_start;
   logic               pack_accept;
   logic               word_full;
   logic [WORD_W-1:0]  packed_word;
   logic [IDX_W-1:0]   idx_plus1;
   logic [CNT_W-1:0]   hdr_count;

   assign accept      = byte_valid_i && ready_q;
   assign load_start  = load_req_i && is_restartable(state_q);
   assign pack_accept = accept && (state_q == ST_DATA);
   assign idx_plus1   = idx_q + IDX_W'(1);
   assign hdr_count   = {byte_data_i, count_q[7:0]};

   byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (load_start),
      .accept_i    (pack_accept),
      .byte_i      (byte_data_i),
      .word_o      (packed_word),
      .word_full_o (word_full)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (load_req_i) begin
                  state_q <= ST_CLEAR;
                  idx_q   <= '0;
                  count_q <= '0;
                  we_q    <= 1'b1;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  start_q <= 1'b0;
               end
            end

            ST_CLEAR: begin
               if (int'(idx_q) == WORD_COUNT - 1) begin
                  state_q <= ST_HDR_LO;
                  idx_q   <= '0;
                  we_q    <= 1'b0;
                  addr_q  <= '0;
                  ready_q <= 1'b1;
               end else begin
                  idx_q  <= idx_plus1;
                  addr_q <= idx_plus1[ADDR_W-1:0];
               end
            end

            ST_HDR_LO: begin
               if (accept) begin
                  count_q[7:0] <= byte_data_i;
                  state_q      <= ST_HDR_HI;
               end
            end

            ST_HDR_HI: begin
               if (accept) begin
                  count_q[15:8] <= byte_data_i;
                  if (hdr_count == '0) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     start_q <= 1'b1;
                  end else if (int'(hdr_count) > WORD_COUNT) begin
                     state_q <= ST_ERR;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (word_full) begin
                  state_q <= ST_WRITE;
                  ready_q <= 1'b0;
                  we_q    <= 1'b1;
                  addr_q  <= idx_q[ADDR_W-1:0];
               end
            end

            ST_WRITE: begin
               we_q   <= 1'b0;
               addr_q <= '0;
               idx_q  <= idx_plus1;
               if (int'(idx_plus1) == int'(count_q)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  start_q <= 1'b1;
               end else begin
                  state_q <= ST_DATA;
                  ready_q <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The packer holds the completed word for exactly the WRITE cycle.
   assign mem_wdata_o  = (state_q == ST_WRITE) ? packed_word : '0;
   assign byte_ready_o = ready_q;
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign cpu_start_o  = start_q;

endmodule
